// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the UART transmitter: write strobe, data word and FIFO/line status.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 wr_en;
    logic [DATA_BITS-1:0] din;
    logic                 full;
    logic                 empty;
    logic                 busy;

    modport master (output wr_en, output din, input full, input empty, input busy);
    modport slave  (input wr_en, input din, output full, output empty, output busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO; frames go out back-to-back
// while the FIFO holds data. Configurable data width, parity and stop bits.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus,
    output logic           tx
);

    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;
    localparam int unsigned TMR_W     = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned BCNT_W    = $clog2(DATA_BITS);
    localparam logic        PAR_ODD   = 1'(PARITY == 1);
    localparam logic        PAR_EN    = 1'(PARITY != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_tx;
    logic [TMR_W-1:0]      r_timer;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_busy;
    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];

    state_t                w_state_nxt;
    logic                  w_tx_nxt;
    logic [TMR_W-1:0]      w_timer_nxt;
    logic [BCNT_W-1:0]     w_bcnt_nxt;
    logic [DATA_BITS-1:0]  w_shift_nxt;
    logic                  w_par_nxt;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_bit_end;
    logic                  w_push;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [DATA_BITS-1:0]  w_head;

    assign w_push    = bus.wr_en & ~r_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_timer == TMR_W'(BIT_TICKS - 1));

    // Next-state and datapath decode; a load pops the head word and opens a start bit.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_timer_nxt = r_timer;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_pop       = 1'b0;
        w_load      = 1'b0;

        if (r_state != IDLE) begin
            w_timer_nxt = w_bit_end ? '0 : r_timer + TMR_W'(1);
        end

        case (r_state)
            IDLE: begin
                if (!r_empty) begin
                    w_load = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                    w_bcnt_nxt  = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bcnt == BCNT_W'(DATA_BITS - 1)) begin
                        w_bcnt_nxt = '0;
                        if (PAR_EN) begin
                            w_state_nxt = PAR;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_nxt    = r_shift[1];
                        w_bcnt_nxt  = r_bcnt + BCNT_W'(1);
                    end
                end
            end
            PAR: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                    w_bcnt_nxt  = '0;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_bcnt == BCNT_W'(STOP_BITS - 1)) begin
                        w_bcnt_nxt = '0;
                        if (!r_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Parity is computed once per word at pop time, over DATA_BITS bits only.
        if (w_load) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_par_nxt   = (^w_head) ^ PAR_ODD;
            w_tx_nxt    = 1'b0;
            w_timer_nxt = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = START;
        end
    end

    // FIFO occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tx     <= 1'b1;
            r_timer  <= '0;
            r_bcnt   <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx     <= w_tx_nxt;
            r_timer  <= w_timer_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_empty  <= (w_count_nxt == '0);
            r_busy   <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    assign tx        = r_tx;
    assign bus.full  = r_full;
    assign bus.empty = r_empty;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 with a 4-deep FIFO, plus 7E2 and 7O2 variants,
// all at 10 clocks per bit. Expected line patterns are hand-computed, first bit in bit 0.
module tb_uart_tx_fifo;

    localparam int unsigned BT = 10;

    logic clk;
    logic rst_n;
    logic tx_a, tx_b, tx_c;
    int   n_checks;
    int   n_fail;

    uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if_b ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if_c ();

    uart_tx_fifo #(
        .CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a), .tx(tx_a));

    uart_tx_fifo #(
        .CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b), .tx(tx_b));

    uart_tx_fifo #(
        .CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(7),
        .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c), .tx(tx_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return if_a.busy;
            1:       return if_b.busy;
            default: return if_c.busy;
        endcase
    endfunction

    // One write strobe, sampled on the next rising edge; returns 1 time unit after it.
    task automatic push(input int sel, input logic [7:0] d);
        case (sel)
            0:       begin if_a.din = d;      if_a.wr_en = 1'b1; end
            1:       begin if_b.din = d[6:0]; if_b.wr_en = 1'b1; end
            default: begin if_c.din = d[6:0]; if_c.wr_en = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if_a.wr_en = 1'b0;
        if_b.wr_en = 1'b0;
        if_c.wr_en = 1'b0;
    endtask

    // Samples tx on BT falling edges per bit; every sample must match and busy must hold.
    task automatic frame_check(input int sel, input logic [11:0] pat, input int nbits,
                               input string tag);
        int busy_hi;
        busy_hi = 0;
        for (int i = 0; i < nbits; i++) begin
            int match;
            match = 0;
            for (int c = 0; c < int'(BT); c++) begin
                @(negedge clk);
                if (get_tx(sel) == pat[i]) match++;
                if (get_busy(sel)) busy_hi++;
            end
            check_eq($sformatf("%s_b%0d", tag, i), 32'(match), 32'(BT));
        end
        check_eq({tag, "_busy"}, 32'(busy_hi), 32'(nbits * int'(BT)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        if_a.wr_en = 1'b0; if_a.din = '0;
        if_b.wr_en = 1'b0; if_b.din = '0;
        if_c.wr_en = 1'b0; if_c.din = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_eq("rst_tx",    32'(tx_a),       32'd1);
        check_eq("rst_busy",  32'(if_a.busy),  32'd0);
        check_eq("rst_empty", 32'(if_a.empty), 32'd1);
        check_eq("rst_full",  32'(if_a.full),  32'd0);
        check_eq("rst_tx_b",  32'(tx_b),       32'd1);
        check_eq("rst_emp_c", 32'(if_c.empty), 32'd1);

        // 7 data bits, even parity, 2 stop: 0x07 -> 0,1,1,1,0,0,0,0,P=1,1,1
        push(1, 8'h07);
        @(negedge clk);
        check_eq("e72_lat", 32'(tx_b), 32'd1);
        frame_check(1, 12'h70E, 11, "e72");
        @(posedge clk); #1;
        check_eq("e72_idle", 32'(if_b.busy), 32'd0);
        @(negedge clk);

        // Same word with odd parity -> parity bit 0
        push(2, 8'h07);
        @(negedge clk);
        check_eq("o72_lat", 32'(tx_c), 32'd1);
        frame_check(2, 12'h60E, 11, "o72");
        @(posedge clk); #1;
        check_eq("o72_idle", 32'(if_c.busy), 32'd0);
        @(negedge clk);

        // 8N1 0x55, with A1..A5 burst in mid-frame: A5 dropped on a full 4-deep FIFO
        push(0, 8'h55);
        check_eq("f55_busy0", 32'(if_a.busy), 32'd1);
        @(negedge clk);
        check_eq("f55_lat",   32'(tx_a),       32'd1);
        check_eq("f55_empty", 32'(if_a.empty), 32'd0);
        fork
            begin
                frame_check(0, 12'h2AA, 10, "f55");
                frame_check(0, 12'h342, 10, "fA1");
                frame_check(0, 12'h344, 10, "fA2");
                frame_check(0, 12'h346, 10, "fA3");
            end
            begin
                repeat (20) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    if_a.din   = 8'(32'hA1 + k);
                    if_a.wr_en = 1'b1;
                    @(posedge clk); #1;
                    if (k == 2) check_eq("burst_nfull", 32'(if_a.full), 32'd0);
                    if (k == 3) check_eq("burst_full",  32'(if_a.full), 32'd1);
                end
                if_a.wr_en = 1'b0;
                check_eq("burst_cnt",  32'(dut_a.r_count), 32'd4);
                check_eq("burst_full2", 32'(if_a.full),   32'd1);
            end
        join
        check_eq("a4_pre_empty", 32'(if_a.empty), 32'd0);
        @(posedge clk); #1;
        check_eq("a4_pop_empty", 32'(if_a.empty), 32'd1);
        frame_check(0, 12'h348, 10, "fA4");
        @(posedge clk); #1;
        check_eq("a4_end_busy", 32'(if_a.busy), 32'd0);
        check_eq("a4_end_tx",   32'(tx_a),      32'd1);
        @(negedge clk);

        // Push coinciding with the stop-end pop while two entries are queued
        push(0, 8'h11);
        @(negedge clk);
        fork
            frame_check(0, 12'h222, 10, "f11");
            begin
                repeat (5) @(negedge clk);
                push(0, 8'h22);
                push(0, 8'h33);
            end
        join
        check_eq("pp_pre_cnt", 32'(dut_a.r_count), 32'd2);
        if_a.din   = 8'h44;
        if_a.wr_en = 1'b1;
        @(posedge clk); #1;
        if_a.wr_en = 1'b0;
        check_eq("pp_cnt",   32'(dut_a.r_count), 32'd2);
        check_eq("pp_empty", 32'(if_a.empty),    32'd0);
        frame_check(0, 12'h244, 10, "f22");
        frame_check(0, 12'h266, 10, "f33");
        frame_check(0, 12'h288, 10, "f44");
        @(posedge clk); #1;
        check_eq("pp_end_busy", 32'(if_a.busy), 32'd0);
        @(negedge clk);

        // Reset during data bit 3 of 0xF0 (bit value 0) with two words queued
        push(0, 8'hF0);
        push(0, 8'h66);
        push(0, 8'h77);
        repeat (44) @(negedge clk);
        check_eq("mid_tx",    32'(tx_a),            32'd0);
        check_eq("mid_cnt",   32'(dut_a.r_count),   32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_tx",    32'(tx_a),          32'd1);
        check_eq("arst_busy",  32'(if_a.busy),     32'd0);
        check_eq("arst_empty", 32'(if_a.empty),    32'd1);
        check_eq("arst_cnt",   32'(dut_a.r_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_tx",   32'(tx_a),      32'd1);
        check_eq("post_busy", 32'(if_a.busy), 32'd0);
        push(0, 8'h3C);
        @(negedge clk);
        check_eq("f3c_lat", 32'(tx_a), 32'd1);
        frame_check(0, 12'h278, 10, "f3C");
        @(posedge clk); #1;
        check_eq("f3c_end_busy", 32'(if_a.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised next-generation UART transmitter with an integrated transmit FIFO.
- Supports configurable data width, parity and stop-bit count.
- Transmits frames back-to-back while the FIFO holds data, so the producer can burst bytes without polling busy.
- Sits between an on-chip byte producer (controller/debug logic) and the FPGA UART TX pin.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, serial bit rate; BIT_TICKS = CLK_FREQ / BAUD (integer truncation), must be >= 2
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, legal 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  push din into the FIFO this cycle
din  input  DATA_BITS  data word to transmit, LSB sent first
full  output  1  FIFO full; writes ignored while high
empty  output  1  FIFO empty
busy  output  1  high while the FIFO is non-empty or a frame is in progress
tx  output  1  serial line, idle high, registered

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n).
- Reset values: tx = 1, busy = 0, empty = 1, full = 0, FSM = IDLE, FIFO pointers/count = 0, bit timer = 0, bit counter = 0.
- Reset mid-frame aborts the frame immediately: tx returns high and the FIFO contents are discarded.
- FIFO:
  - Write is accepted when wr_en = 1 and full = 0, both sampled at the edge; a write while full is dropped with no overwrite or state change.
  - A simultaneous accepted write and FSM pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
  - full and empty are derived from the registered count.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: when empty = 0, pop the head word into a shift register, set tx = 0, clear the timer, go to START.
  - Bit timing: each state holds its tx value for exactly BIT_TICKS clocks. The timer counts 0..BIT_TICKS-1; the bit ends on the edge where timer == BIT_TICKS-1, and the timer then reloads to 0.
  - START -> DATA: tx = data[0].
  - DATA: after each bit, shift to the next bit. After DATA_BITS bits, go to PAR if PARITY != 0, otherwise to STOP.
  - PAR: tx = XOR of the data bits for even parity, inverted for odd; lasts one bit time, then go to STOP.
  - STOP: tx = 1 for STOP_BITS bit times. At the end:
    - FIFO non-empty: pop immediately, tx = 0, go to START. No idle gap; the next start bit begins on the clock after the last stop-bit clock.
    - FIFO empty: go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BIT_TICKS clocks.
- Latency: a write at edge E0 into an empty idle block drives tx low from edge E1 (one clock).
- busy = (state != IDLE) | ~empty. It deasserts on the same edge that the final stop bit completes with an empty FIFO.
- din is only sampled at write; changes to din after the write do not affect queued data.
- Unused upper bits: none. Data is exactly DATA_BITS wide, and parity covers only those bits.

Test Plan:
- CLK_FREQ = 100M, BAUD = 10M (BIT_TICKS = 10), 8N1: write 0x55 → tx pattern 0,1,0,1,0,1,0,1,0,1, each exactly 10 clocks; busy high for 100 clocks then low; tx falls 1 clock after the write.
- PARITY = 2, DATA_BITS = 7, STOP_BITS = 2: write 0x07 → 7 data bits 1,1,1,0,0,0,0, parity bit 1, two stop bits; frame = 110 clocks. Repeat with PARITY = 1 → parity bit 0.
- FIFO_DEPTH = 4: write 0xA1..0xA5 on 5 consecutive clocks → full after the 4th accepted write; 0xA5 is dropped; bytes A1, A2, A3, A4 go out back-to-back with no idle high between stop and start; empty asserts when A4 is popped.
- Simultaneous push/pop: with the FIFO holding 2 entries, assert wr_en on the stop-end pop edge → count stays 2 and the data order is preserved.
- Reset mid-frame: deassert rst_n during DATA bit 3 with 2 queued bytes → tx = 1, busy = 0, empty = 1 asynchronously. After release, a write of 0x3C transmits cleanly.
- Write during an active frame while not full → byte queued, current frame unaffected, busy stays high continuously through both frames.
